// File: rtl/baccarat_dealer_ctrl.sv
// baccarat_dealer_ctrl: baccarat hand sequencer; define BACCARAT_STATS_EN to add saturating win/tie counters
module baccarat_dealer_ctrl #(
   parameter int SCORE_W = 4
`ifdef BACCARAT_STATS_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic               slow_clock,
   input  logic               reset,
   input  logic               start,
   input  logic               card_valid,
   input  logic [SCORE_W-1:0] pscore,
   input  logic [SCORE_W-1:0] bscore,
   input  logic [SCORE_W-1:0] pcard3,
   output logic               card_req,
   output logic               hand_clr,
   output logic               load_pcard1,
   output logic               load_pcard2,
   output logic               load_pcard3,
   output logic               load_bcard1,
   output logic               load_bcard2,
   output logic               load_bcard3,
   output logic               player_win_light,
   output logic               dealer_win_light,
   output logic               busy
`ifdef BACCARAT_STATS_EN
   , output logic [CNT_W-1:0] player_wins
   , output logic [CNT_W-1:0] banker_wins
   , output logic [CNT_W-1:0] ties
`endif
);
   typedef enum logic [3:0] {
      IDLE, DEAL_P1, DEAL_B1, DEAL_P2, DEAL_B2, CHK_NAT, DEAL_P3, CHK_B, DEAL_B3, RESULT, DONE
   } state_t;
   state_t state_q, state_d;
   logic pl_q, pl_d, dl_q, dl_d;
   logic [SCORE_W-1:0] v;
   logic bdraw, natural;
   assign v = (pcard3 >= SCORE_W'(10)) ? '0 : pcard3;
   assign natural = (pscore >= SCORE_W'(8)) | (bscore >= SCORE_W'(8));
   assign bdraw = (bscore <= SCORE_W'(2))
                | ((bscore == SCORE_W'(3)) & (v != SCORE_W'(8)))
                | ((bscore == SCORE_W'(4)) & (v >= SCORE_W'(2)) & (v <= SCORE_W'(7)))
                | ((bscore == SCORE_W'(5)) & (v >= SCORE_W'(4)) & (v <= SCORE_W'(7)))
                | ((bscore == SCORE_W'(6)) & (v >= SCORE_W'(6)) & (v <= SCORE_W'(7)));
   assign busy = (state_q != IDLE) & (state_q != DONE);
   assign player_win_light = pl_q;
   assign dealer_win_light = dl_q;
   // state and win lights; reset clears lights immediately
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pl_q <= 1'b0;
         dl_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pl_q <= pl_d;
         dl_q <= dl_d;
      end
   end
   // hand sequencing, card handshake strobes and third-card decisions
   always_comb begin
      state_d = state_q;
      pl_d = pl_q;
      dl_d = dl_q;
      card_req = 1'b0;
      hand_clr = 1'b0;
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_bcard1 = 1'b0;
      load_bcard2 = 1'b0;
      load_bcard3 = 1'b0;
      case (state_q)
         IDLE, DONE: if (start && !reset) begin
            hand_clr = 1'b1;
            pl_d = 1'b0;
            dl_d = 1'b0;
            state_d = DEAL_P1;
         end
         DEAL_P1: begin
            card_req = 1'b1;
            load_pcard1 = card_valid;
            state_d = card_valid ? DEAL_B1 : state_q;
         end
         DEAL_B1: begin
            card_req = 1'b1;
            load_bcard1 = card_valid;
            state_d = card_valid ? DEAL_P2 : state_q;
         end
         DEAL_P2: begin
            card_req = 1'b1;
            load_pcard2 = card_valid;
            state_d = card_valid ? DEAL_B2 : state_q;
         end
         DEAL_B2: begin
            card_req = 1'b1;
            load_bcard2 = card_valid;
            state_d = card_valid ? CHK_NAT : state_q;
         end
         CHK_NAT: state_d = natural ? RESULT : (pscore <= SCORE_W'(5)) ? DEAL_P3 :
                            (bscore <= SCORE_W'(5)) ? DEAL_B3 : RESULT;
         DEAL_P3: begin
            card_req = 1'b1;
            load_pcard3 = card_valid;
            state_d = card_valid ? CHK_B : state_q;
         end
         CHK_B: state_d = bdraw ? DEAL_B3 : RESULT;
         DEAL_B3: begin
            card_req = 1'b1;
            load_bcard3 = card_valid;
            state_d = card_valid ? RESULT : state_q;
         end
         RESULT: begin
            pl_d = pscore >= bscore;
            dl_d = bscore >= pscore;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
`ifdef BACCARAT_STATS_EN
   logic [CNT_W-1:0] pw_q, bw_q, tie_q;
   assign player_wins = pw_q;
   assign banker_wins = bw_q;
   assign ties = tie_q;
   // outcome counters, saturating, cleared only by reset
   always_ff @(posedge slow_clock or posedge reset) begin
      if (reset) begin
         pw_q <= '0;
         bw_q <= '0;
         tie_q <= '0;
      end else if (state_q == RESULT) begin
         if (pscore > bscore && !(&pw_q)) pw_q <= pw_q + CNT_W'(1);
         if (bscore > pscore && !(&bw_q)) bw_q <= bw_q + CNT_W'(1);
         if (pscore == bscore && !(&tie_q)) tie_q <= tie_q + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_baccarat_dealer_ctrl.sv
// tb_baccarat_dealer_ctrl: directed and random hands checked against a rules-level baccarat model
module tb_baccarat_dealer_ctrl;
   logic slow_clock = 1'b0, reset = 1'b1, start = 1'b0, card_valid = 1'b0;
   logic [3:0] pscore, bscore, pcard3;
   logic card_req, hand_clr, busy, plw, dlw;
   logic load_pcard1, load_pcard2, load_pcard3, load_bcard1, load_bcard2, load_bcard3;
   logic [5:0] ld;
`ifdef BACCARAT_STATS_EN
   logic [7:0] player_wins, banker_wins, ties;
`endif
   int errs = 0, checks = 0;
   int deck[6] = '{0, 0, 0, 0, 0, 0};
   int pc[3] = '{0, 0, 0};
   int bc[3] = '{0, 0, 0};
   int strobes[6] = '{0, 0, 0, 0, 0, 0};
   int di = 0;

   baccarat_dealer_ctrl dut (
      .slow_clock(slow_clock), .reset(reset), .start(start), .card_valid(card_valid),
      .pscore(pscore), .bscore(bscore), .pcard3(pcard3),
      .card_req(card_req), .hand_clr(hand_clr),
      .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
      .load_bcard1(load_bcard1), .load_bcard2(load_bcard2), .load_bcard3(load_bcard3),
      .player_win_light(plw), .dealer_win_light(dlw), .busy(busy)
`ifdef BACCARAT_STATS_EN
      , .player_wins(player_wins), .banker_wins(banker_wins), .ties(ties)
`endif
   );

   always #5 slow_clock = ~slow_clock;

   function automatic int val(input int c);
      return (c >= 10) ? 0 : c;
   endfunction

   assign ld = {load_bcard3, load_bcard2, load_bcard1, load_pcard3, load_pcard2, load_pcard1};
   assign pscore = 4'((val(pc[0]) + val(pc[1]) + val(pc[2])) % 10);
   assign bscore = 4'((val(bc[0]) + val(bc[1]) + val(bc[2])) % 10);
   assign pcard3 = 4'(pc[2]);

   // card registers and scorehand stand-in: latch the next deck card on each strobe
   always @(posedge slow_clock) begin
      if (hand_clr) begin
         pc <= '{0, 0, 0};
         bc <= '{0, 0, 0};
         strobes <= '{0, 0, 0, 0, 0, 0};
         di <= 0;
      end else begin
         for (int k = 0; k < 6; k++) if (ld[k]) begin
            if (k < 3) pc[k] <= deck[di];
            else bc[k-3] <= deck[di];
            strobes[k] <= strobes[k] + 1;
         end
         if (|ld) di <= di + 1;
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // whole-hand baccarat rules on the dealt card sequence P1,B1,P2,B2,then third cards
   function automatic void model(input int c[6], output int np, output int nb,
                                 output int pl, output int dl);
      int p, b, t;
      p = (val(c[0]) + val(c[2])) % 10;
      b = (val(c[1]) + val(c[3])) % 10;
      np = 0;
      nb = 0;
      if (p < 8 && b < 8) begin
         if (p <= 5) begin
            np = 1;
            t = val(c[4]);
            p = (p + t) % 10;
            case (b)
               0, 1, 2: nb = 1;
               3: nb = int'(t != 8);
               4: nb = int'(t >= 2 && t <= 7);
               5: nb = int'(t >= 4 && t <= 7);
               6: nb = int'(t >= 6 && t <= 7);
               default: nb = 0;
            endcase
         end else nb = int'(b <= 5);
         if (nb == 1) b = (b + val(c[4 + np])) % 10;
      end
      pl = int'(p >= b);
      dl = int'(b >= p);
   endfunction

   task automatic wait_done(input bit rnd, output int cyc);
      cyc = 1;
      while (busy && cyc < 300) begin
         if (rnd) card_valid = ($urandom_range(0, 3) != 0);
         @(negedge slow_clock);
         cyc++;
      end
   endtask

   task automatic play(input bit rnd, input string tag);
      int np, nb, pl, dl, cyc;
      model(deck, np, nb, pl, dl);
      @(negedge slow_clock);
      start = 1'b1;
      card_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1 check({tag, "/hand_clr"}, int'(hand_clr), 1);
      @(negedge slow_clock);
      start = 1'b0;
      check({tag, "/lights_clr"}, int'({plw, dlw}), 0);
      check({tag, "/busy"}, int'(busy), 1);
      wait_done(rnd, cyc);
      check({tag, "/done"}, int'(busy), 0);
      if (!rnd) check({tag, "/latency"}, cyc, 7 + 2 * np + nb);
      check({tag, "/strobes"}, strobes[0] + strobes[1] + strobes[3] + strobes[4], 4);
      check({tag, "/pcard3_loads"}, strobes[2], np);
      check({tag, "/bcard3_loads"}, strobes[5], nb);
      check({tag, "/player_light"}, int'(plw), pl);
      check({tag, "/dealer_light"}, int'(dlw), dl);
   endtask

   initial begin
      int cyc;
      #1;
      check("rst/outputs", int'({ld, card_req, hand_clr, busy, plw, dlw}), 0);
      @(negedge slow_clock);
      reset = 1'b0;
      deck = '{4, 2, 5, 3, 1, 1};
      play(1'b0, "natural");
      deck = '{1, 2, 2, 2, 12, 0};
      play(1'b0, "bank_stands");
      deck = '{1, 2, 2, 2, 5, 4};
      play(1'b0, "both_draw_tie");
      deck = '{3, 2, 4, 3, 7, 0};
      play(1'b0, "player_stands");
      // stall three cycles in DEAL_B1
      deck = '{4, 2, 5, 3, 1, 1};
      @(negedge slow_clock);
      start = 1'b1;
      card_valid = 1'b1;
      @(negedge slow_clock);
      start = 1'b0;
      @(negedge slow_clock);
      card_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall/req_no_strobe", int'({card_req, ld}), 64);
         @(negedge slow_clock);
      end
      card_valid = 1'b1;
      #1 check("stall/bcard1_same_cycle", int'(ld), 8);
      wait_done(1'b0, cyc);
      check("stall/done", int'(busy), 0);
      check("stall/bcard1_once", strobes[3], 1);
      check("stall/lights", int'({plw, dlw}), 2);
      // reset while in DEAL_P2 with a strobe pending
      @(negedge slow_clock);
      start = 1'b1;
      @(negedge slow_clock);
      start = 1'b0;
      @(negedge slow_clock);
      @(negedge slow_clock);
      #1 check("midrst/pcard2_pending", int'(ld), 2);
      #1 reset = 1'b1;
      #1 check("midrst/outputs", int'({ld, card_req, hand_clr, busy, plw, dlw}), 0);
      @(negedge slow_clock);
      reset = 1'b0;
      play(1'b0, "after_rst");
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < 6; k++) deck[k] = int'($urandom_range(1, 13));
         play(i[0], "random");
      end
`ifdef BACCARAT_STATS_EN
      @(negedge slow_clock);
      reset = 1'b1;
      @(negedge slow_clock);
      reset = 1'b0;
      deck = '{4, 2, 5, 3, 1, 1};
      play(1'b0, "st_pwin");
      deck = '{1, 2, 2, 2, 5, 4};
      play(1'b0, "st_tie");
      deck = '{1, 2, 2, 2, 12, 0};
      play(1'b0, "st_bwin");
      check("stats/111", int'({player_wins, banker_wins, ties}), 24'h010101);
      deck = '{4, 2, 5, 3, 1, 1};
      play(1'b0, "st_again");
      check("stats/start_keeps", int'({player_wins, banker_wins, ties}), 24'h020101);
      #1 reset = 1'b1;
      #1 check("stats/reset_clears", int'({player_wins, banker_wins, ties}), 0);
      @(negedge slow_clock);
      reset = 1'b0;
`endif
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
